// File: rtl/uart_rx_engine_pkg.sv
// Shared definitions for the UART receive engine.
// Holds the FSM state encoding, the cfg byte field positions (the same layout the transmitter
// uses), the latched-config struct and small helper functions.
package uart_rx_engine_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } rx_state_e;

  // cfg byte field positions; bits [7:5] are reserved
  localparam int unsigned CfgDbitsLsb = 0;
  localparam int unsigned CfgPen      = 2;
  localparam int unsigned CfgPodd     = 3;
  localparam int unsigned CfgStop2    = 4;

  typedef struct packed {
    logic       stop2;
    logic       podd;
    logic       pen;
    logic [1:0] dbits;  // data bits minus 5
  } rx_cfg_t;

  function automatic rx_cfg_t decode_cfg(logic [4:0] c);
    rx_cfg_t r;
    r.dbits = c[CfgDbitsLsb +: 2];
    r.pen   = c[CfgPen];
    r.podd  = c[CfgPodd];
    r.stop2 = c[CfgStop2];
    return r;
  endfunction

  function automatic logic majority3(logic a, logic b, logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_engine_if.sv
// Consumer-side handshake of the UART receive engine.
//   rx_data    received byte, LSB-aligned
//   rx_valid   rx_data holds an unread byte
//   rx_ack     consumer accepts the byte (only meaningful while rx_valid=1)
//   rx_busy    a frame is being received
//   parity_err parity mismatch for the held byte
//   frame_err  a stop bit of the held byte's frame was low
//   overrun    sticky: a frame finished while rx_valid was already set
//   irq        rx_valid | overrun
// master = receive engine, slave = consumer.
interface uart_rx_engine_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       rx_busy;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       irq;

  modport master (
    output rx_data, rx_valid, rx_busy, parity_err, frame_err, overrun, irq,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, rx_busy, parity_err, frame_err, overrun, irq,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx_engine_baud_tick.sv
// Oversample tick generator for the UART receiver.
//   clk, rst   system clock, synchronous active-high reset
//   baud_div   clk cycles per tick (0 behaves as 1)
//   restart    realign the counter to 0 (start-edge detect)
//   tick       one-clk pulse when the counter wraps
// The divisor is captured on wrap/restart so a changed baud_div takes effect cleanly.
module uart_rx_engine_baud_tick (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic        restart,
  output logic        tick
);

  logic [15:0] cnt_q, cnt_d;
  logic [15:0] div_q, div_d;
  logic [15:0] lim;

  always_comb begin
    lim   = (div_q == 16'd0) ? 16'd0 : div_q - 16'd1;
    tick  = (cnt_q == lim);
    cnt_d = cnt_q + 16'd1;
    div_d = div_q;
    if (restart || tick) begin
      cnt_d = 16'd0;
      div_d = baud_div;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
      div_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: 16x (OSR) oversampling, 3-sample majority vote at each bit centre,
// 5..8 data bits, optional parity, one or two stop bits.
//   clk, rst   system clock, synchronous active-high reset
//   cfg        [1:0] data bits-5, [2] parity en, [3] odd parity, [4] two stop bits;
//              latched at start-edge detect
//   baud_div   clk cycles per oversample tick
//   rx         asynchronous serial input, idle high
//   rx_if      byte/flag handshake towards the consumer (master side)
module uart_rx_engine
  import uart_rx_engine_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OSR         = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             cfg,
  input  logic [15:0]            baud_div,
  input  logic                   rx,
  uart_rx_engine_if.master       rx_if
);

  localparam int unsigned SW = $clog2(OSR);
  // sample_q holds (sample number - 1) within the current bit
  localparam logic [SW-1:0] SLo  = SW'(OSR / 2 - 2);
  localparam logic [SW-1:0] SMid = SW'(OSR / 2 - 1);
  localparam logic [SW-1:0] SHi  = SW'(OSR / 2);
  localparam logic [SW-1:0] SEnd = SW'(OSR - 1);

  logic unused_cfg;
  assign unused_cfg = ^cfg[7:5];

  rx_state_e             state_q, state_d;
  rx_cfg_t               cfg_q, cfg_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                  rxs, rxs_prev_q, rxs_prev_d;
  logic [SW-1:0]         sample_q, sample_d;
  logic [2:0]            bit_q, bit_d;
  logic [1:0]            samp_q, samp_d;
  logic [7:0]            shreg_q, shreg_d;
  logic                  perr_acc_q, perr_acc_d;
  logic                  ferr_acc_q, ferr_acc_d;
  logic [7:0]            rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;

  logic       tick, restart, vote;
  logic [2:0] last_data, last_stop;
  logic [7:0] data_al;

  uart_rx_engine_baud_tick u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .baud_div (baud_div),
    .restart  (restart),
    .tick     (tick)
  );

  assign sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  assign rxs    = sync_q[SYNC_STAGES-1];

  assign last_data = 3'd4 + {1'b0, cfg_q.dbits};
  assign last_stop = {2'b00, cfg_q.stop2};
  // Bits enter at the top, so short words sit high in shreg and must be shifted down
  assign data_al   = shreg_q >> (2'd3 - cfg_q.dbits);
  assign vote      = majority3(samp_q[0], samp_q[1], rxs);

  always_comb begin
    state_d      = state_q;
    cfg_d        = cfg_q;
    rxs_prev_d   = rxs;
    sample_d     = sample_q;
    bit_d        = bit_q;
    samp_d       = samp_q;
    shreg_d      = shreg_q;
    perr_acc_d   = perr_acc_q;
    ferr_acc_d   = ferr_acc_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = rx_valid_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = overrun_q;
    restart      = 1'b0;

    if (rx_if.rx_ack && rx_valid_q) begin
      rx_valid_d   = 1'b0;
      parity_err_d = 1'b0;
      frame_err_d  = 1'b0;
      overrun_d    = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        // A line held low (break) produces no new falling edge until it has returned high
        if (rxs_prev_q && !rxs) begin
          restart    = 1'b1;
          cfg_d      = decode_cfg(cfg[4:0]);
          sample_d   = '0;
          bit_d      = 3'd0;
          shreg_d    = 8'd0;
          perr_acc_d = 1'b0;
          ferr_acc_d = 1'b0;
          state_d    = StStart;
        end
      end
      StDone: begin
        state_d = StIdle;
        if (rx_valid_q && !rx_if.rx_ack) begin
          overrun_d = 1'b1;
        end else begin
          rx_data_d    = data_al;
          parity_err_d = perr_acc_q;
          frame_err_d  = ferr_acc_q;
          rx_valid_d   = 1'b1;
        end
      end
      default: begin
        if (tick) begin
          sample_d = sample_q + 1'b1;
          if (sample_q == SLo)  samp_d[0] = rxs;
          if (sample_q == SMid) samp_d[1] = rxs;
          if (sample_q == SHi) begin
            case (state_q)
              StStart:  if (vote) state_d = StIdle;
              StData:   shreg_d = {vote, shreg_q[7:1]};
              StParity: perr_acc_d = vote ^ (^data_al) ^ cfg_q.podd;
              StStop: begin
                if (!vote) ferr_acc_d = 1'b1;
                // Finish at the centre of the last stop bit to resync early for the next frame
                if (bit_q == last_stop) state_d = StDone;
              end
              default: ;
            endcase
          end
          if (sample_q == SEnd) begin
            sample_d = '0;
            case (state_q)
              StStart: begin
                state_d = StData;
                bit_d   = 3'd0;
              end
              StData: begin
                if (bit_q == last_data) begin
                  bit_d   = 3'd0;
                  state_d = cfg_q.pen ? StParity : StStop;
                end else begin
                  bit_d = bit_q + 3'd1;
                end
              end
              StParity: begin
                state_d = StStop;
                bit_d   = 3'd0;
              end
              StStop:  bit_d = bit_q + 3'd1;
              default: ;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      cfg_q        <= '0;
      sync_q       <= '1;
      rxs_prev_q   <= 1'b1;
      sample_q     <= '0;
      bit_q        <= 3'd0;
      samp_q       <= 2'b00;
      shreg_q      <= 8'd0;
      perr_acc_q   <= 1'b0;
      ferr_acc_q   <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      sync_q       <= sync_d;
      rxs_prev_q   <= rxs_prev_d;
      sample_q     <= sample_d;
      bit_q        <= bit_d;
      samp_q       <= samp_d;
      shreg_q      <= shreg_d;
      perr_acc_q   <= perr_acc_d;
      ferr_acc_q   <= ferr_acc_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_if.rx_data    = rx_data_q;
  assign rx_if.rx_valid   = rx_valid_q;
  assign rx_if.rx_busy    = (state_q != StIdle);
  assign rx_if.parity_err = parity_err_q;
  assign rx_if.frame_err  = frame_err_q;
  assign rx_if.overrun    = overrun_q;
  assign rx_if.irq        = rx_valid_q | overrun_q;

endmodule
